// File: rtl/imem_rr_arb_pkg.sv
// imem_arb_pkg: shared FSM encoding and round-robin search helper for imem_rr_arb
// Contents: arb_state_t (RUN/CLEAR), MAXREQ bound, rr_find() first-set search from a pointer
package imem_arb_pkg;
  typedef enum logic {RUN, CLEAR} arb_state_t;
  localparam int MAXREQ = 16;
  // Returns {found, index} of the first set bit of req at or after ptr, wrapping at n.
  function automatic logic [4:0] rr_find(input logic [MAXREQ-1:0] req, input logic [3:0] ptr, input int n);
    logic [4:0] r;
    int j;
    r = '0;
    for (int i = MAXREQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= n) j = j - n;
      if (i < n && req[j[3:0]]) r = {1'b1, j[3:0]};
    end
    return r;
  endfunction
endpackage

// File: rtl/imem_rr_arb_if.sv
// imem_rr_arb_if: requester, RAM-port and clear-control signals of imem_rr_arb
// slave: arbiter view (takes requests and mem_do, drives grants, read return, mem_* and clear status)
// master: environment view (clients plus RAM wrapper)
interface imem_rr_arb_if #(
  parameter int ADDRBIT = 9,
  parameter int WIDTH = 32,
  parameter int NREQ = 4,
  parameter int IDBIT = 2
);
  logic [NREQ-1:0] req_we;
  logic [NREQ-1:0] req_re;
  logic [NREQ*ADDRBIT-1:0] req_wa;
  logic [NREQ*ADDRBIT-1:0] req_ra;
  logic [NREQ*WIDTH-1:0] req_wd;
  logic [NREQ-1:0] gnt_w;
  logic [NREQ-1:0] gnt_r;
  logic rvld;
  logic [IDBIT-1:0] rid;
  logic [WIDTH-1:0] rdata;
  logic [ADDRBIT-1:0] mem_wa;
  logic [ADDRBIT-1:0] mem_ra;
  logic mem_we;
  logic mem_re;
  logic [WIDTH-1:0] mem_di;
  logic [WIDTH-1:0] mem_do;
  logic init_start;
  logic init_busy;
  logic init_done;
  modport slave (
    input  req_we, req_wa, req_wd, req_re, req_ra, mem_do, init_start,
    output gnt_w, gnt_r, rvld, rid, rdata, mem_wa, mem_we, mem_di, mem_ra, mem_re, init_busy, init_done
  );
  modport master (
    output req_we, req_wa, req_wd, req_re, req_ra, mem_do, init_start,
    input  gnt_w, gnt_r, rvld, rid, rdata, mem_wa, mem_we, mem_di, mem_ra, mem_re, init_busy, init_done
  );
endinterface

// File: rtl/imem_rr_arb_rr_pick.sv
// rr_pick: round-robin picker returning a one-hot grant and the advanced pointer
// Ports: req/elig request and eligibility masks, ptr search start, gnt one-hot grant, nxt next pointer
module rr_pick
  import imem_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] elig,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   nxt
);
  logic [MAXREQ-1:0] cand;
  logic [4:0] hit;
  always_comb begin
    cand = '0;
    cand[NREQ-1:0] = req & elig;
    hit = rr_find(cand, 4'(ptr), NREQ);
    gnt = hit[4] ? NREQ'(1) << hit[3:0] : '0;
    nxt = !hit[4] ? ptr : (hit[3:0] == 4'(NREQ - 1)) ? '0 : PW'(hit[3:0] + 4'd1);
  end
endmodule

// File: rtl/imem_rr_arb.sv
// imem_rr_arb: round-robin sharing of one dual-port RAM among NREQ requesters with clear sweep
// Ports: clk, rst (sync, active high); bus (slave) carries requests, grants, tagged read return,
// the registered mem_* write/read ports, mem_do, and init_start/init_busy/init_done
module imem_rr_arb
  import imem_arb_pkg::*;
#(
  parameter int ADDRBIT = 9,
  parameter int DEPTH = 512,
  parameter int WIDTH = 32,
  parameter int NREQ = 4,
  parameter int IDBIT = 2,
  parameter int RDLAT = 3,
  parameter int HAZWIN = 2,
  parameter string CLR_ON_RST = "ON"
) (
  input logic clk,
  input logic rst,
  imem_rr_arb_if.slave bus
);
  localparam int HD = HAZWIN > 1 ? HAZWIN - 1 : 1;
  localparam logic [ADDRBIT-1:0] LAST = ADDRBIT'(DEPTH - 1);
  localparam arb_state_t RST_ST = (CLR_ON_RST == "ON") ? CLEAR : RUN;
  arb_state_t state, state_nx;
  logic run, last, any_w, any_r;
  logic [ADDRBIT-1:0] caddr;
  logic [IDBIT-1:0] wptr, rptr, wptr_nx, rptr_nx;
  logic [NREQ-1:0] gnt_w, gnt_r, elig_r;
  logic [ADDRBIT-1:0] wa_sel, ra_sel;
  logic [WIDTH-1:0] wd_sel;
  logic [IDBIT-1:0] rid_sel, mem_id;
  // Past granted writes; the current cycle's write is compared combinationally.
  logic [HD-1:0] hv;
  logic [ADDRBIT-1:0] ha [HD];
  // Read return tracker fed from the registered read port, so its tail lines up with mem_do.
  logic [RDLAT-1:0] tv;
  logic [IDBIT-1:0] tid [RDLAT];
  always_comb begin
    run = state == RUN;
    last = state == CLEAR && caddr == LAST;
    state_nx = state;
    if (run && bus.init_start) state_nx = CLEAR;
    if (last) state_nx = RUN;
  end
  rr_pick #(.NREQ(NREQ), .PW(IDBIT)) u_wpick (
    .req(bus.req_we & {NREQ{run}}),
    .elig({NREQ{1'b1}}),
    .ptr(wptr),
    .gnt(gnt_w),
    .nxt(wptr_nx)
  );
  rr_pick #(.NREQ(NREQ), .PW(IDBIT)) u_rpick (
    .req(bus.req_re & {NREQ{run}}),
    .elig(elig_r),
    .ptr(rptr),
    .gnt(gnt_r),
    .nxt(rptr_nx)
  );
  assign any_w = |gnt_w;
  assign any_r = |gnt_r;
  always_comb begin
    wa_sel = '0;
    wd_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      wa_sel |= gnt_w[k] ? bus.req_wa[k*ADDRBIT +: ADDRBIT] : '0;
      wd_sel |= gnt_w[k] ? bus.req_wd[k*WIDTH +: WIDTH] : '0;
    end
  end
  always_comb begin
    elig_r = '0;
    for (int k = 0; k < NREQ; k++) begin
      elig_r[k] = !(any_w && bus.req_ra[k*ADDRBIT +: ADDRBIT] == wa_sel);
      for (int i = 0; i < HAZWIN - 1; i++)
        elig_r[k] &= !(hv[i] && ha[i] == bus.req_ra[k*ADDRBIT +: ADDRBIT]);
    end
  end
  always_comb begin
    ra_sel = '0;
    rid_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      ra_sel |= gnt_r[k] ? bus.req_ra[k*ADDRBIT +: ADDRBIT] : '0;
      rid_sel |= gnt_r[k] ? IDBIT'(k) : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state <= RST_ST;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      caddr <= '0;
      wptr <= '0;
      rptr <= '0;
      hv <= '0;
      tv <= '0;
      for (int i = 0; i < RDLAT; i++) tid[i] <= '0;
      mem_id <= '0;
      bus.mem_we <= 1'b0;
      bus.mem_wa <= '0;
      bus.mem_di <= '0;
      bus.mem_re <= 1'b0;
      bus.mem_ra <= '0;
      bus.init_done <= 1'b0;
    end else begin
      caddr <= (state == CLEAR && !last) ? caddr + 1'b1 : '0;
      wptr <= wptr_nx;
      rptr <= rptr_nx;
      hv[0] <= any_w;
      ha[0] <= wa_sel;
      for (int i = 1; i < HD; i++) begin
        hv[i] <= hv[i-1];
        ha[i] <= ha[i-1];
      end
      tv[0] <= bus.mem_re;
      tid[0] <= mem_id;
      for (int i = 1; i < RDLAT; i++) begin
        tv[i] <= tv[i-1];
        tid[i] <= tid[i-1];
      end
      mem_id <= rid_sel;
      bus.mem_we <= !run || any_w;
      bus.mem_wa <= run ? wa_sel : caddr;
      bus.mem_di <= run ? wd_sel : '0;
      bus.mem_re <= any_r;
      bus.mem_ra <= ra_sel;
      bus.init_done <= last;
    end
  end
  assign bus.gnt_w = gnt_w;
  assign bus.gnt_r = gnt_r;
  assign bus.rvld = tv[RDLAT-1];
  assign bus.rid = tid[RDLAT-1];
  assign bus.rdata = bus.mem_do;
  assign bus.init_busy = state == CLEAR;
endmodule
